pcie_tx_framer: RTL



---
 rtl/pcie_framing_pkg.sv | 28 ++
 rtl/frame_byte_packer.sv | 32 +++
 rtl/pcie_tx_framer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pcie_framing_pkg.sv
// Shared framing constants, symbol codes and packet-state enum for the PCIe TX framer.
package pcie_framing_pkg;

  localparam int IN_BYTES     = 8;
  localparam int OUT_BYTES    = 64;
  localparam int SLOTS        = IN_BYTES + 3;
  localparam int ACCEPT_LIMIT = OUT_BYTES - SLOTS;
  localparam int DLLP_LEN     = 6;

  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IN_TLP,
    ST_IN_DLLP
  } pkt_state_e;

  // Lanes below n are occupied.
  function automatic logic [OUT_BYTES-1:0] lane_mask(input logic [6:0] n);
    lane_mask = '0;
    for (int i = 0; i < OUT_BYTES; i++)
      if (7'(i) < n) lane_mask[i] = 1'b1;
  endfunction

endpackage

// File: rtl/frame_byte_packer.sv
// Places up to SLOTS tagged bytes into the lane accumulator starting at lane fill.
module frame_byte_packer
  import pcie_framing_pkg::*;
(
  input  logic [8*OUT_BYTES-1:0] acc_data,
  input  logic [OUT_BYTES-1:0]   acc_dk,
  input  logic [6:0]             fill,
  input  logic [8*SLOTS-1:0]     add_data,
  input  logic [SLOTS-1:0]       add_dk,
  input  logic [3:0]             add_cnt,
  output logic [8*OUT_BYTES-1:0] packed_data,
  output logic [OUT_BYTES-1:0]   packed_dk,
  output logic [6:0]             new_fill
);

  always_comb begin
    logic [7:0] pos;
    pos         = '0;
    packed_data = acc_data;
    packed_dk   = acc_dk;
    for (int k = 0; k < SLOTS; k++) begin
      pos = {1'b0, fill} + 8'(k);
      if (4'(k) < add_cnt && pos < 8'(OUT_BYTES)) begin
        packed_data[{pos[5:0], 3'b000} +: 8] = add_data[8*k +: 8];
        packed_dk[pos[5:0]]                  = add_dk[k];
      end
    end
  end

  assign new_fill = fill + {3'b000, add_cnt};

endmodule

// File: rtl/pcie_tx_framer.sv
// PCIe TX framer: wraps link-layer beats in STP/SDP..END/EDB and packs them into 64-lane words.
//
// state      | meaning
// ST_IDLE    | between packets, only a sop beat is legal
// ST_IN_TLP  | inside a TLP, waiting for eop
// ST_IN_DLLP | inside a DLLP, counting payload bytes
module pcie_tx_framer
  import pcie_framing_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*IN_BYTES-1:0]  in_data,
  input  logic [3:0]             in_len,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic                   in_is_dllp,
  input  logic                   in_nullify,
  output logic [8*OUT_BYTES-1:0] Data_out,
  output logic [OUT_BYTES-1:0]   DK,
  output logic [OUT_BYTES-1:0]   valid,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic                   proto_err
);

  pkt_state_e             state;
  logic [3:0]             dllp_cnt;
  logic [8*OUT_BYTES-1:0] acc_data;
  logic [OUT_BYTES-1:0]   acc_dk;
  logic [6:0]             fill;

  logic                   accept, beat_drop, close_req, close_fire, is_dllp_pkt;
  logic [8*SLOTS-1:0]     add_data;
  logic [SLOTS-1:0]       add_dk;
  logic [3:0]             add_cnt;
  logic [8*OUT_BYTES-1:0] packed_data;
  logic [OUT_BYTES-1:0]   packed_dk;
  logic [6:0]             new_fill;
  logic [4:0]             dllp_sum;
  logic [3:0]             dllp_next;

  assign in_ready    = (fill <= 7'(ACCEPT_LIMIT));
  assign accept      = in_valid && in_ready;
  assign beat_drop   = (in_len == 4'd0) || (in_len > 4'(IN_BYTES)) || (state == ST_IDLE && !in_sop);
  // Close and accept are mutually exclusive: a full accumulator already drops in_ready.
  assign close_req   = (fill > 7'(ACCEPT_LIMIT)) || (fill != 7'd0 && !accept);
  assign close_fire  = close_req && (!word_valid || word_ready);
  assign is_dllp_pkt = in_sop ? in_is_dllp : (state == ST_IN_DLLP);
  assign dllp_sum    = (in_sop ? 5'd0 : {1'b0, dllp_cnt}) + {1'b0, in_len};
  assign dllp_next   = dllp_sum[4] ? 4'hF : dllp_sum[3:0];

  always_comb begin
    add_data = '0;
    add_dk   = '0;
    add_cnt  = '0;
    if (!beat_drop) begin
      if (in_sop && state != ST_IDLE) begin
        add_data[{add_cnt, 3'b000} +: 8] = SYM_EDB;
        add_dk[add_cnt]                  = 1'b1;
        add_cnt                          = add_cnt + 4'd1;
      end
      if (in_sop) begin
        add_data[{add_cnt, 3'b000} +: 8] = in_is_dllp ? SYM_SDP : SYM_STP;
        add_dk[add_cnt]                  = 1'b1;
        add_cnt                          = add_cnt + 4'd1;
      end
      for (int j = 0; j < IN_BYTES; j++) begin
        if (4'(j) < in_len) begin
          add_data[{add_cnt, 3'b000} +: 8] = in_data[8*j +: 8];
          add_cnt                          = add_cnt + 4'd1;
        end
      end
      if (in_eop) begin
        add_data[{add_cnt, 3'b000} +: 8] = in_nullify ? SYM_EDB : SYM_END;
        add_dk[add_cnt]                  = 1'b1;
        add_cnt                          = add_cnt + 4'd1;
      end
    end
  end

  frame_byte_packer u_packer (
    .acc_data    (acc_data),
    .acc_dk      (acc_dk),
    .fill        (fill),
    .add_data    (add_data),
    .add_dk      (add_dk),
    .add_cnt     (add_cnt),
    .packed_data (packed_data),
    .packed_dk   (packed_dk),
    .new_fill    (new_fill)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      dllp_cnt   <= '0;
      acc_data   <= '0;
      acc_dk     <= '0;
      fill       <= '0;
      Data_out   <= '0;
      DK         <= '0;
      valid      <= '0;
      word_valid <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if (accept) begin
        if (beat_drop) begin
          proto_err <= 1'b1;
        end else begin
          acc_data <= packed_data;
          acc_dk   <= packed_dk;
          fill     <= new_fill;
          dllp_cnt <= dllp_next;
          if (in_sop && state != ST_IDLE) proto_err <= 1'b1;
          if (in_eop) begin
            state <= ST_IDLE;
            if (is_dllp_pkt && dllp_next != 4'(DLLP_LEN)) proto_err <= 1'b1;
          end else if (in_sop) begin
            state <= in_is_dllp ? ST_IN_DLLP : ST_IN_TLP;
          end
        end
      end else if (close_fire) begin
        Data_out   <= acc_data;
        DK         <= acc_dk;
        valid      <= lane_mask(fill);
        word_valid <= 1'b1;
        acc_data   <= '0;
        acc_dk     <= '0;
        fill       <= '0;
      end
      if (!close_fire && word_valid && word_ready) word_valid <= 1'b0;
    end
  end

endmodule
